// File: rtl/win_line_scanner_if.sv
// Scan request, board read port and result bus of win_line_scanner.
interface win_line_scanner_if #(
  parameter int unsigned ROW_W   = 3,
  parameter int unsigned COL_W   = 3,
  parameter int unsigned PIECE_W = 2
);
  logic               start;
  logic [ROW_W-1:0]   row;
  logic [COL_W-1:0]   col;
  logic               rd_en;
  logic [ROW_W-1:0]   rd_row;
  logic [COL_W-1:0]   rd_col;
  logic [PIECE_W-1:0] data_in;
  logic               busy;
  logic               done;
  logic [PIECE_W-1:0] winner;
  logic [1:0]         win_axis;
  logic               err;

  // Controller/board side: issues scans and serves board reads.
  modport master (
    output start, row, col, data_in,
    input  rd_en, rd_row, rd_col, busy, done, winner, win_axis, err
  );

  // Scanner side.
  modport slave (
    input  start, row, col, data_in,
    output rd_en, rd_row, rd_col, busy, done, winner, win_axis, err
  );
endinterface

// File: rtl/win_line_scanner.sv
// Walks outward from a freshly dropped piece along four axes, one board read
// per cycle, and reports the winning player/axis, no winner, or a bad origin.
module win_line_scanner #(
  parameter int unsigned ROWS    = 6,
  parameter int unsigned COLS    = 7,
  parameter int unsigned ROW_W   = 3,
  parameter int unsigned COL_W   = 3,
  parameter int unsigned WIN_LEN = 4,
  parameter int unsigned PIECE_W = 2
) (
  input logic              clk,
  input logic              rst,
  win_line_scanner_if.slave bus
);
  localparam int unsigned CNT_W  = $clog2(WIN_LEN + 1);
  localparam int unsigned STEP_W = ROW_W + COL_W + 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ORIGIN = 2'd1;
  localparam logic [1:0] S_SCAN   = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]         state_q,  state_n;
  logic [ROW_W-1:0]   org_r_q,  org_r_n;
  logic [COL_W-1:0]   org_c_q,  org_c_n;
  logic [PIECE_W-1:0] ref_q,    ref_n;
  logic [CNT_W-1:0]   count_q,  count_n;
  logic [CNT_W-1:0]   dist_q,   dist_n;
  logic [1:0]         axis_q,   axis_n;
  logic               neg_q,    neg_n;
  logic               rd_en_q,  rd_en_n;
  logic [ROW_W-1:0]   rd_row_q, rd_row_n;
  logic [COL_W-1:0]   rd_col_q, rd_col_n;
  logic               busy_q,   busy_n;
  logic               done_q,   done_n;
  logic [PIECE_W-1:0] winner_q, winner_n;
  logic [1:0]         waxis_q,  waxis_n;
  logic               err_q,    err_n;

  logic [STEP_W-1:0]  cont_s, ray_s, org_s;
  logic [CNT_W-1:0]   cnt_inc;
  logic [1:0]         nxt_ax;
  logic               nxt_neg;
  logic               hit;
  logic               ray_end;

  // One step from (r,c) along axis ax, negated when neg; coordinates are one
  // bit wider so a step below zero or past the edge lands out of range.
  function automatic logic [STEP_W-1:0] step(input logic [ROW_W-1:0] r,
                                             input logic [COL_W-1:0] c,
                                             input logic [1:0]       ax,
                                             input logic             neg);
    logic [ROW_W:0] nr;
    logic [COL_W:0] nc;
    logic           inb;
    nr = {1'b0, r};
    nc = {1'b0, c};
    if (ax != 2'd0)
      nr = neg ? nr - (ROW_W+1)'(1) : nr + (ROW_W+1)'(1);
    if (ax == 2'd0 || ax == 2'd2)
      nc = neg ? nc - (COL_W+1)'(1) : nc + (COL_W+1)'(1);
    else if (ax == 2'd3)
      nc = neg ? nc + (COL_W+1)'(1) : nc - (COL_W+1)'(1);
    inb = (nr < (ROW_W+1)'(ROWS)) && (nc < (COL_W+1)'(COLS));
    return {inb, nr[ROW_W-1:0], nc[COL_W-1:0]};
  endfunction

  // Next-state and next-output logic.
  always_comb begin
    state_n  = state_q;
    org_r_n  = org_r_q;
    org_c_n  = org_c_q;
    ref_n    = ref_q;
    count_n  = count_q;
    dist_n   = dist_q;
    axis_n   = axis_q;
    neg_n    = neg_q;
    rd_en_n  = 1'b0;
    rd_row_n = rd_row_q;
    rd_col_n = rd_col_q;
    winner_n = winner_q;
    waxis_n  = waxis_q;
    err_n    = err_q;
    ray_end  = 1'b0;

    cnt_inc = count_q + CNT_W'(1);
    hit     = rd_en_q && (bus.data_in == ref_q);
    nxt_ax  = neg_q ? axis_q + 2'd1 : axis_q;
    nxt_neg = ~neg_q;
    cont_s  = step(rd_row_q, rd_col_q, axis_q, neg_q);
    ray_s   = step(org_r_q, org_c_q, nxt_ax, nxt_neg);
    org_s   = step(org_r_q, org_c_q, 2'd0, 1'b0);

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          org_r_n  = bus.row;
          org_c_n  = bus.col;
          winner_n = '0;
          waxis_n  = 2'd0;
          if (({1'b0, bus.row} >= (ROW_W+1)'(ROWS)) ||
              ({1'b0, bus.col} >= (COL_W+1)'(COLS))) begin
            err_n   = 1'b1;
            state_n = S_DONE;
          end else begin
            err_n    = 1'b0;
            rd_en_n  = 1'b1;
            rd_row_n = bus.row;
            rd_col_n = bus.col;
            state_n  = S_ORIGIN;
          end
        end
      end
      S_ORIGIN: begin
        ref_n = bus.data_in;
        if (bus.data_in == '0) begin
          state_n = S_DONE;
        end else begin
          count_n = CNT_W'(1);
          axis_n  = 2'd0;
          neg_n   = 1'b0;
          dist_n  = CNT_W'(1);
          rd_en_n = org_s[STEP_W-1];
          if (org_s[STEP_W-1]) begin
            rd_row_n = org_s[ROW_W+COL_W-1:COL_W];
            rd_col_n = org_s[COL_W-1:0];
          end
          state_n = S_SCAN;
        end
      end
      S_SCAN: begin
        ray_end = 1'b1;
        if (hit) begin
          count_n = cnt_inc;
          if (cnt_inc == CNT_W'(WIN_LEN)) begin
            winner_n = ref_q;
            waxis_n  = axis_q;
            state_n  = S_DONE;
            ray_end  = 1'b0;
          end else if (cont_s[STEP_W-1] && (dist_q < CNT_W'(WIN_LEN - 1))) begin
            rd_en_n  = 1'b1;
            rd_row_n = cont_s[ROW_W+COL_W-1:COL_W];
            rd_col_n = cont_s[COL_W-1:0];
            dist_n   = dist_q + CNT_W'(1);
            ray_end  = 1'b0;
          end
        end
        if (ray_end) begin
          if (neg_q && axis_q == 2'd3) begin
            state_n = S_DONE;
          end else begin
            // Negative ray keeps the count; a new axis restarts it at the origin.
            if (neg_q) count_n = CNT_W'(1);
            axis_n  = nxt_ax;
            neg_n   = nxt_neg;
            dist_n  = CNT_W'(1);
            rd_en_n = ray_s[STEP_W-1];
            if (ray_s[STEP_W-1]) begin
              rd_row_n = ray_s[ROW_W+COL_W-1:COL_W];
              rd_col_n = ray_s[COL_W-1:0];
            end
          end
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    busy_n = (state_n == S_ORIGIN) || (state_n == S_SCAN);
    done_n = (state_n == S_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      org_r_q  <= '0;
      org_c_q  <= '0;
      ref_q    <= '0;
      count_q  <= '0;
      dist_q   <= '0;
      axis_q   <= '0;
      neg_q    <= 1'b0;
      rd_en_q  <= 1'b0;
      rd_row_q <= '0;
      rd_col_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      winner_q <= '0;
      waxis_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_n;
      org_r_q  <= org_r_n;
      org_c_q  <= org_c_n;
      ref_q    <= ref_n;
      count_q  <= count_n;
      dist_q   <= dist_n;
      axis_q   <= axis_n;
      neg_q    <= neg_n;
      rd_en_q  <= rd_en_n;
      rd_row_q <= rd_row_n;
      rd_col_q <= rd_col_n;
      busy_q   <= busy_n;
      done_q   <= done_n;
      winner_q <= winner_n;
      waxis_q  <= waxis_n;
      err_q    <= err_n;
    end
  end

  assign bus.rd_en    = rd_en_q;
  assign bus.rd_row   = rd_row_q;
  assign bus.rd_col   = rd_col_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.winner   = winner_q;
  assign bus.win_axis = waxis_q;
  assign bus.err      = err_q;
endmodule

// File: tb/tb_win_line_scanner.sv
// Directed scenarios for win_line_scanner; expected results are queued at
// start and checked by a monitor whenever done pulses.
module tb_win_line_scanner;
  localparam int unsigned ROWS = 6;
  localparam int unsigned COLS = 7;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;
  int   oob;
  logic watch_rd;
  int   rd_hits;
  logic log_en;
  logic [5:0] addr_log [$];

  typedef struct {
    logic [1:0] winner;
    logic [1:0] axis;
    logic       err;
    int         lat;
    int         start_cyc;
  } exp_t;
  exp_t exp_q [$];

  logic [1:0] board [64];

  win_line_scanner_if #(.ROW_W(3), .COL_W(3), .PIECE_W(2)) bus ();

  win_line_scanner #(
    .ROWS(ROWS), .COLS(COLS), .ROW_W(3), .COL_W(3), .WIN_LEN(4), .PIECE_W(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Combinational board RAM.
  always_comb bus.data_in = board[{bus.rd_row, bus.rd_col}];

  // Scoreboard monitor plus address-range watch.
  always @(negedge clk) begin
    if (bus.rd_row >= 3'(ROWS) || bus.rd_col >= 3'(COLS)) oob++;
    if (watch_rd && bus.rd_en) rd_hits++;
    if (log_en && bus.rd_en) addr_log.push_back({bus.rd_row, bus.rd_col});
    if (bus.done) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: done=1 at cycle %0d, required no done", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (bus.winner !== e.winner || bus.win_axis !== e.axis || bus.err !== e.err) begin
          errors++;
          $display("FAIL result: winner=%0d axis=%0d err=%0d, required winner=%0d axis=%0d err=%0d",
                   bus.winner, bus.win_axis, bus.err, e.winner, e.axis, e.err);
        end
        checks++;
        if (cyc - e.start_cyc != e.lat) begin
          errors++;
          $display("FAIL latency: got %0d cycles, required %0d", cyc - e.start_cyc, e.lat);
        end
      end
    end
  end

  task automatic clear_board();
    for (int i = 0; i < 64; i++) board[i] = 2'd0;
  endtask

  task automatic put(input int r, input int c, input logic [1:0] p);
    logic [5:0] a;
    a = {3'(r), 3'(c)};
    board[a] = p;
  endtask

  task automatic do_start(input int r, input int c, input bit push,
                          input logic [1:0] w, input logic [1:0] ax,
                          input logic er, input int lat);
    exp_t e;
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.row   = 3'(r);
    bus.col   = 3'(c);
    if (push) begin
      e.winner = w; e.axis = ax; e.err = er; e.lat = lat; e.start_cyc = cyc;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL timeout_%s: %0d results pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic check1(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic check_zero_outputs(input string name);
    check1({name, "_out"},
           {24'd0, bus.rd_en, bus.rd_row, bus.rd_col, 1'b0},
           32'd0);
    check1({name, "_stat"},
           {26'd0, bus.busy, bus.done, bus.winner, bus.err, 1'b0} | {30'd0, bus.win_axis},
           32'd0);
  endtask

  initial begin
    cyc = 0; checks = 0; errors = 0; oob = 0;
    watch_rd = 1'b0; rd_hits = 0; log_en = 1'b0;
    bus.start = 1'b0; bus.row = '0; bus.col = '0;
    clear_board();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero_outputs("reset");
    rst = 1'b0;

    // Horizontal win from the left end, with address sequence.
    for (int c = 0; c < 4; c++) put(0, c, 2'd1);
    log_en = 1'b1;
    do_start(0, 0, 1'b1, 2'd1, 2'd0, 1'b0, 5);
    wait_done("horiz");
    log_en = 1'b0;
    check1("horiz_nreads", addr_log.size(), 4);
    for (int i = 0; i < 4 && i < addr_log.size(); i++)
      check1("horiz_addr", 32'(addr_log[i]), 32'({3'd0, 3'(i)}));

    // Vertical win at the right edge.
    clear_board();
    for (int r = 0; r < 4; r++) put(r, 6, 2'd2);
    do_start(3, 6, 1'b1, 2'd2, 2'd1, 1'b0, 8);
    wait_done("vert");

    // Anti-diagonal split across both rays.
    clear_board();
    put(0, 3, 2'd1); put(1, 2, 2'd1); put(2, 1, 2'd1); put(3, 0, 2'd1);
    do_start(1, 2, 1'b1, 2'd1, 2'd3, 1'b0, 11);
    wait_done("anti");

    // Three in a row only: every axis exhausted.
    clear_board();
    put(2, 1, 2'd1); put(2, 2, 2'd1); put(2, 3, 2'd1);
    do_start(2, 2, 1'b1, 2'd0, 2'd0, 1'b0, 12);
    wait_done("three");

    // Out-of-bounds origin: error, no read.
    watch_rd = 1'b1; rd_hits = 0;
    do_start(6, 0, 1'b1, 2'd0, 2'd0, 1'b1, 1);
    wait_done("oob");
    watch_rd = 1'b0;
    check1("oob_no_read", rd_hits, 0);

    // Empty origin cell.
    do_start(5, 5, 1'b1, 2'd0, 2'd0, 1'b0, 2);
    wait_done("empty");
    check1("err_cleared", {31'd0, bus.err}, 0);

    // Reset mid-scan aborts without done.
    clear_board();
    for (int c = 0; c < 4; c++) put(0, c, 2'd1);
    do_start(0, 0, 1'b0, 2'd0, 2'd0, 1'b0, 0);
    @(posedge clk); #1;
    check1("busy_scan", {31'd0, bus.busy}, 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_zero_outputs("midrst");
    rst = 1'b0;
    repeat (12) @(posedge clk);

    // start while busy is ignored.
    do_start(0, 0, 1'b1, 2'd1, 2'd0, 1'b0, 5);
    @(negedge clk);
    check1("busy_hold", {31'd0, bus.busy}, 1);
    bus.start = 1'b1; bus.row = 3'd5; bus.col = 3'd5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done("busy");
    repeat (8) @(posedge clk);

    check1("pending", exp_q.size(), 0);
    check1("addr_range", oob, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/win_line_scanner.md
Name: win_line_scanner

Overview:
- Parametrised, bounds-safe successor to the fixed four-cell direction checker in the Connect-Four engine.
- After each drop, the game controller pulses start with the landing cell.
- The block walks outward from that cell along all four axes, reading the board RAM one cell per cycle.
- It reports the winning player and axis, or no winner, once WIN_LEN in-line pieces are found or every axis is exhausted.

Parameters:
- ROWS, 6, board rows (row 0 = bottom).
- COLS, 7, board columns.
- ROW_W, 3, row index width; must satisfy 2^ROW_W >= ROWS.
- COL_W, 3, column index width; must satisfy 2^COL_W >= COLS.
- WIN_LEN, 4, pieces in line needed to win; legal range 2..max(ROWS,COLS).
- PIECE_W, 2, cell code width; 0 = empty, nonzero = player id.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request scan; accepted only in IDLE
- row  in  ROW_W  origin row, sampled on accepted start
- col  in  COL_W  origin column, sampled on accepted start
- rd_en  out  1  rd_row/rd_col hold a valid in-bounds probe address
- rd_row  out  ROW_W  board read row (registered)
- rd_col  out  COL_W  board read column (registered)
- data_in  in  PIECE_W  board cell at rd_row/rd_col; combinational read, sampled the cycle after the address is registered
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse: result valid
- winner  out  PIECE_W  winning player, or 0; held until the next accepted start
- win_axis  out  2  0 horizontal, 1 vertical, 2 diag (+r,+c), 3 anti-diag (+r,-c); 0 when winner = 0
- err  out  1  origin out of bounds; held like winner

Behaviour:
- Single clock; the only reset is rst, synchronous and active-high.
- Reset values: all outputs 0; state IDLE; internal counters 0. Asserting rst mid-scan aborts the scan with no done pulse.
- States: IDLE, ORIGIN, SCAN, DONE.
- IDLE, start=1:
  - Latch row/col as the origin.
  - If row>=ROWS or col>=COLS: go to DONE with err=1, winner=0, and no read is issued.
  - Otherwise: register rd_row/rd_col = origin, rd_en=1, clear winner/win_axis/err, go to ORIGIN.
- ORIGIN:
  - Sample data_in as ref. If ref=0: DONE, winner=0.
  - Otherwise: count=1, axis=0, ray=positive; register the first in-bounds probe; go to SCAN.
- SCAN:
  - Each cycle with rd_en=1, compare data_in to ref.
  - On a match: count+1. If count+1 = WIN_LEN, go to DONE with winner=ref, win_axis=axis. Otherwise register the next cell on the same ray.
  - On a mismatch, or when the next cell on the ray is out of bounds: switch to the negative ray of the same axis (cell origin-delta) with count kept.
  - After the negative ray ends: next axis, count=1.
  - After axis 3 ends: DONE, winner=0.
- Ray with no in-bounds first cell: costs exactly one SCAN cycle with rd_en=0; data_in is ignored.
- Bounds:
  - Next-cell coordinates are computed one bit wider than ROW_W/COL_W and checked against 0..ROWS-1 and 0..COLS-1.
  - rd_row/rd_col never wrap, and rd_en is never asserted for an out-of-bounds cell.
- Each ray probes at most WIN_LEN-1 cells from the origin.
- DONE: done=1 for exactly one cycle, busy=0 in that cycle, then IDLE.
- start in DONE or while busy is ignored, not queued.
- Latency:
  - Win found on the k-th probed cell: done asserts k+2 cycles after the start cycle.
  - Worst case with no win is bounded by 2 + 8*(WIN_LEN-1) + 8 cycles.
- rd_en is low in IDLE and DONE.

Test Plan:
- 7x6 board, player 1 at (0,0..3). Start at (0,0) -> rd addresses (0,0),(0,1),(0,2),(0,3) on consecutive cycles; done at start+5; winner=1, win_axis=0.
- Player 2 at (0..3,6). Start at (3,6) -> the horizontal axis probes only column 5 (the out-of-bounds column 7 side costs one rd_en=0 cycle); vertical finds the win; winner=2, win_axis=1; rd_col never equals 7.
- Player 1 at (0,3),(1,2),(2,1),(3,0). Start at (1,2) -> the positive anti-diag ray finds (2,1),(3,0), the negative ray finds (0,3); winner=1, win_axis=3.
- Three in a row, (2,1..3), with (2,0) and (2,4) empty; start at (2,2) -> all axes exhausted; winner=0, done within 42 cycles, no out-of-bounds rd address.
- Start at (6,0) with ROWS=6 -> done 1 cycle after start, err=1, rd_en never high. Start at an empty cell -> done at start+2, winner=0.
- Assert rst during SCAN -> next cycle all outputs 0 and no done pulse. start pulsed while busy -> ignored; the result matches the first scan only.
